multicycle_control: RTL

- Multicycle MIPS control FSM. Replaces the single-cycle opcode decoder when the datapath is split into IR/MDR/A/B/ALUOut register stages over one shared instruction/data memory.
- Sequences fetch, decode, execute, memory and writeback per instruction, and drives every datapath mux and enable.
- Stalls on a memory-ready handshake; flags illegal opcodes and memory timeouts.

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the datapath mux select codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RBEXEC = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory request open until mem_ready.
   function automatic logic isMemState(input stateT s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags expiry when the count reaches
// TIMEOUT_CYCLES while the wait is still pending.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic clear,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (waiting && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   // A ready response in the limit cycle keeps waiting low, so it wins.
   assign expired = waiting && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath mux and enable from the current state.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state_dbg,
   output logic       illegal_op,
   output logic       mem_timeout
);

   stateT state;
   stateT nextState;
   logic  badOpcode;
   logic  waiting;
   logic  expired;
   logic  clearWait;

   assign waiting   = isMemState(state) && !mem_ready;
   assign clearWait = (nextState != state) || expired;
   assign state_dbg = state;

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) waitTimer (
      .clk    (clk),
      .rst_n  (rst_n),
      .waiting(waiting),
      .clear  (clearWait),
      .expired(expired)
   );

   always_comb begin : nextStateLogic
      nextState = FETCH;
      badOpcode = 1'b0;
      case (state)
         FETCH:  nextState = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: nextState = MEMADR;
               OP_RTYPE:     nextState = RBEXEC;
               OP_BEQ:       nextState = BRANCH;
               OP_ADDI:      nextState = ADDIEX;
               OP_J:         nextState = JUMP;
               default: begin
                  nextState = FETCH;
                  badOpcode = 1'b1;
               end
            endcase
         end
         MEMADR: nextState = (Opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  nextState = mem_ready ? MEMWB : MEMRD;
         MEMWR:  nextState = mem_ready ? FETCH : MEMWR;
         RBEXEC: nextState = RWB;
         ADDIEX: nextState = ADDIWB;
         default: nextState = FETCH;
      endcase
      // Abandoned accesses restart at FETCH without any write side effect.
      if (expired) nextState = FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state <= nextState;
         if (badOpcode) illegal_op  <= 1'b1;
         if (expired)   mem_timeout <= 1'b1;
      end
   end

   always_comb begin : outputDecode
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         DECODE: ALUSrcB = SRCB_IMMSH;
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         RBEXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         ADDIWB: RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         default: ;
      endcase
      // Reset holds FETCH, so its requests and enables must be masked here.
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         MemRead     = 1'b0;
      end
   end

endmodule
